pos_sweep_eval: RTL and testbench

- Parametrised, programmable product-of-sums evaluator for an N_VARS-input boolean function. A maxterm table is loaded one entry at a time.
- Arbitrary input vectors are evaluated with a registered output.
- A built-in sweep mode streams the full truth table, one row per cycle, and counts the rows that evaluate to zero.
- Serves as the reusable self-checking function block for the boolean-expression exercises, replacing fixed hand-written PoS modules.

---
 rtl/pos_eval_pkg.sv | 8 +
 rtl/pos_tt_mem.sv | 25 ++
 rtl/pos_sweep_eval.sv | 79 +++++++
 tb/tb_pos_sweep_eval.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/pos_eval_pkg.sv
// pos_eval_pkg: shared default width, sweep FSM encoding and table-depth helper
package pos_eval_pkg;
  localparam int N_VARS_DEF = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, SWEEP = 2'd1, DONE = 2'd2} state_t;
  function automatic int depth(input int n);
    return 1 << n;
  endfunction
endpackage

// File: rtl/pos_tt_mem.sv
// pos_tt_mem: 2**N_VARS x 1 truth-table register file, resets to all ones
// ports: clk, reset (sync, high); we/waddr/wdata write port;
//        eval_idx->eval_row and sweep_idx->sweep_row combinational reads
module pos_tt_mem
  import pos_eval_pkg::*;
#(
  parameter int N_VARS = N_VARS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [N_VARS-1:0] waddr,
  input  logic              wdata,
  input  logic [N_VARS-1:0] eval_idx,
  output logic              eval_row,
  input  logic [N_VARS-1:0] sweep_idx,
  output logic              sweep_row
);
  logic [depth(N_VARS)-1:0] rows;
  always_ff @(posedge clk)
    if (reset) rows <= '1;
    else if (we) rows[waddr] <= wdata;
  assign eval_row  = rows[eval_idx];
  assign sweep_row = rows[sweep_idx];
endmodule

// File: rtl/pos_sweep_eval.sv
// pos_sweep_eval: programmable product-of-sums evaluator with full-table sweep
// ports: clk, reset (sync, high); load_en/load_idx/load_maxterm table write;
//        eval_in -> s (registered); start_sweep -> busy, sweep_valid,
//        sweep_idx, sweep_s, done pulse, zero_count (rows with S=0)
module pos_sweep_eval
  import pos_eval_pkg::*;
#(
  parameter int N_VARS = N_VARS_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en,
  input  logic [N_VARS-1:0] load_idx,
  input  logic              load_maxterm,
  input  logic [N_VARS-1:0] eval_in,
  output logic              s,
  input  logic              start_sweep,
  output logic              busy,
  output logic              sweep_valid,
  output logic [N_VARS-1:0] sweep_idx,
  output logic              sweep_s,
  output logic              done,
  output logic [N_VARS:0]   zero_count
);
  localparam logic [N_VARS:0] LAST = (N_VARS+1)'(depth(N_VARS) - 1);
  state_t state, state_nxt;
  logic [N_VARS:0] cnt, acc;
  logic row_e, row_c, idle_ok;
  // registered outputs trail the state by a cycle, so the done pulse cycle is
  // also kept closed to writes and new sweeps
  assign idle_ok = state == IDLE && !done;
  pos_tt_mem #(.N_VARS(N_VARS)) u_mem (
    .clk       (clk),
    .reset     (reset),
    .we        (load_en && idle_ok),
    .waddr     (load_idx),
    .wdata     (~load_maxterm),
    .eval_idx  (eval_in),
    .eval_row  (row_e),
    .sweep_idx (cnt[N_VARS-1:0]),
    .sweep_row (row_c)
  );
  always_comb
    state_nxt = state == IDLE  ? (start_sweep && idle_ok ? SWEEP : IDLE) :
                state == SWEEP ? (cnt == LAST ? DONE : SWEEP) : IDLE;
  always_ff @(posedge clk)
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      s           <= 1'b1;
      busy        <= 1'b0;
      sweep_valid <= 1'b0;
      sweep_idx   <= '0;
      sweep_s     <= 1'b0;
      done        <= 1'b0;
      zero_count  <= '0;
    end else begin
      state       <= state_nxt;
      s           <= row_e;
      sweep_valid <= state == SWEEP;
      done        <= state == DONE;
      if (state == IDLE && state_nxt == SWEEP) begin
        cnt  <= '0;
        acc  <= '0;
        busy <= 1'b1;
      end
      if (state == SWEEP) begin
        sweep_idx <= cnt[N_VARS-1:0];
        sweep_s   <= row_c;
        acc       <= acc + {{N_VARS{1'b0}}, ~row_c};
        cnt       <= cnt + 1'b1;
      end
      if (state == DONE) begin
        busy       <= 1'b0;
        zero_count <= acc;
      end
    end
endmodule

// File: tb/tb_pos_sweep_eval.sv
// tb_pos_sweep_eval: directed self-checking bench for pos_sweep_eval (N_VARS 4 and 2)
module tb_pos_sweep_eval;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic load_en = 1'b0, load_maxterm = 1'b0, start_sweep = 1'b0;
  logic [3:0] load_idx = '0, eval_in = '0;
  logic s, busy, sweep_valid, sweep_s, done;
  logic [3:0] sweep_idx;
  logic [4:0] zero_count;
  logic load_en2 = 1'b0, load_maxterm2 = 1'b0, start2 = 1'b0;
  logic [1:0] load_idx2 = '0, eval_in2 = '0;
  logic s2, busy2, valid2, ss2, done2;
  logic [1:0] idx2;
  logic [2:0] zc2;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pos_sweep_eval #(.N_VARS(4)) dut (
    .clk(clk), .reset(reset), .load_en(load_en), .load_idx(load_idx),
    .load_maxterm(load_maxterm), .eval_in(eval_in), .s(s),
    .start_sweep(start_sweep), .busy(busy), .sweep_valid(sweep_valid),
    .sweep_idx(sweep_idx), .sweep_s(sweep_s), .done(done), .zero_count(zero_count)
  );

  pos_sweep_eval #(.N_VARS(2)) dut2 (
    .clk(clk), .reset(reset), .load_en(load_en2), .load_idx(load_idx2),
    .load_maxterm(load_maxterm2), .eval_in(eval_in2), .s(s2),
    .start_sweep(start2), .busy(busy2), .sweep_valid(valid2),
    .sweep_idx(idx2), .sweep_s(ss2), .done(done2), .zero_count(zc2)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(input logic [3:0] idx, input logic mt);
    load_en = 1'b1; load_idx = idx; load_maxterm = mt;
    step();
    load_en = 1'b0;
  endtask

  // rows: expected S per row (bit i = row i); disturb pokes a write and a
  // restart mid-sweep that must both be ignored
  task automatic sweep4(input logic [15:0] rows, input int exp_zc, input bit disturb);
    int nvalid = 0;
    int done_at = -1;
    int ndone = 0;
    start_sweep = 1'b1;
    step();
    start_sweep = 1'b0;
    check("busy_after_start", busy, 1);
    for (int c = 1; c <= 24; c++) begin
      if (disturb && c == 5) begin
        load_en = 1'b1; load_idx = 4'd2; load_maxterm = rows[2]; start_sweep = 1'b1;
      end
      step();
      if (disturb && c == 5) begin
        load_en = 1'b0; start_sweep = 1'b0;
      end
      if (disturb && c == 10) check("zero_count_hold", zero_count, exp_zc);
      if (sweep_valid) begin
        if (nvalid < 16) begin
          check("sweep_idx", sweep_idx, nvalid);
          check("sweep_s", sweep_s, rows[nvalid]);
        end
        nvalid++;
      end
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = c;
      end
    end
    check("valid_rows", nvalid, 16);
    check("done_cycle", done_at, 17);
    check("done_pulses", ndone, 1);
    check("zero_count", zero_count, exp_zc);
    check("busy_end", busy, 0);
  endtask

  initial begin
    int found;
    int nd;
    int nv;
    int da;
    step();
    step();
    check("rst_s", s, 1);
    check("rst_busy", busy, 0);
    check("rst_valid", sweep_valid, 0);
    check("rst_idx", sweep_idx, 0);
    check("rst_sweep_s", sweep_s, 0);
    check("rst_done", done, 0);
    check("rst_zc", zero_count, 0);
    check("rst_zc2", zc2, 0);
    reset = 1'b0;
    step();
    sweep4(16'hFFFF, 0, 1'b0);
    load(4'd0, 1'b1); load(4'd1, 1'b1); load(4'd6, 1'b1); load(4'd7, 1'b1);
    load(4'd8, 1'b1); load(4'd9, 1'b1); load(4'd12, 1'b1); load(4'd14, 1'b1);
    sweep4(16'hAC3C, 8, 1'b0);
    eval_in = 4'b1100;
    step();
    check("eval_12", s, 0);
    eval_in = 4'b1101;
    step();
    check("eval_13", s, 1);
    load(4'd13, 1'b1);
    check("rbw_old", s, 1);
    step();
    check("rbw_new", s, 0);
    load(4'd13, 1'b0);
    step();
    check("restore_13", s, 1);
    sweep4(16'hAC3C, 8, 1'b1);
    start_sweep = 1'b1;
    step();
    start_sweep = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && found == 0; c++) begin
      step();
      if (sweep_valid && sweep_idx == 4'd5) found = 1;
    end
    check("reached_row5", found, 1);
    reset = 1'b1;
    step();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", sweep_valid, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_zc", zero_count, 0);
    check("mid_rst_s", s, 1);
    reset = 1'b0;
    nd = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (done) nd++;
    end
    check("no_done_after_rst", nd, 0);
    sweep4(16'hFFFF, 0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      load_en2 = 1'b1; load_idx2 = 2'(i); load_maxterm2 = 1'b1;
      step();
    end
    load_en2 = 1'b0;
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    nv = 0;
    da = -1;
    for (int c = 1; c <= 10; c++) begin
      step();
      if (valid2) begin
        if (nv < 4) begin
          check("n2_idx", idx2, nv);
          check("n2_sweep_s", ss2, 0);
        end
        nv++;
      end
      if (done2 && da < 0) da = c;
    end
    check("n2_valid_rows", nv, 4);
    check("n2_done_cycle", da, 5);
    check("n2_zero_count", zc2, 3'b100);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
